// File: rtl/bru_pkg.sv
// bru_pkg: shared types and default widths for the branch resolve unit.
package bru_pkg;
    localparam int BRU_PC_WIDTH   = 32;
    localparam int BRU_DATA_WIDTH = 32;
    localparam int BRU_FIFO_DEPTH = 4;
    localparam int BRU_CNT_WIDTH  = 32;

    typedef enum logic {
        BR_BEQ = 1'b0,
        BR_BNE = 1'b1
    } br_sel_e;

    typedef struct packed {
        logic [BRU_PC_WIDTH-1:0] pc;
        logic                    taken;
        logic                    mispredict;
    } bru_rec_t;
endpackage

// File: rtl/bru_train_fifo.sv
// bru_train_fifo: synchronous FIFO of branch training records, head shown from registered storage.
module bru_train_fifo
    import bru_pkg::*;
#(
    parameter int DEPTH = BRU_FIFO_DEPTH
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  logic     pop,
    input  bru_rec_t wr_rec,
    output bru_rec_t rd_rec,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    bru_rec_t    mem_q [DEPTH];

    always_comb begin
        wr_d   = push ? wr_q + ONE : wr_q;
        rd_d   = pop ? rd_q + ONE : rd_q;
        empty  = wr_q == rd_q;
        full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        rd_rec = empty ? '0 : mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= wr_rec;
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-stage beq/bne resolution, flush/redirect, predictor training queue.
// Statistics counters are built only when BRU_STATS_EN is defined.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int PC_WIDTH   = BRU_PC_WIDTH,
    parameter int DATA_WIDTH = BRU_DATA_WIDTH,
    parameter int FIFO_DEPTH = BRU_FIFO_DEPTH,
    parameter int CNT_WIDTH  = BRU_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic                  ex_is_branch,
    input  logic                  ex_branch_ne,
    input  logic [DATA_WIDTH-1:0] ex_rs_data,
    input  logic [DATA_WIDTH-1:0] ex_rt_data,
    input  logic [PC_WIDTH-1:0]   ex_pc,
    input  logic [PC_WIDTH-1:0]   ex_target,
    input  logic [PC_WIDTH-1:0]   ex_save_pc,
    input  logic                  ex_prediction,
    output logic                  flush,
    output logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  stall,
    output logic                  train_valid,
    input  logic                  train_ready,
    output logic [PC_WIDTH-1:0]   train_pc,
    output logic                  train_taken,
    output logic                  train_mispredict,
    output logic [CNT_WIDTH-1:0]  branch_count,
    output logic [CNT_WIDTH-1:0]  mispredict_count
);
    logic     resolve, eq, taken, wrong, push, pop, full, empty;
    bru_rec_t wr_rec, rd_rec;

    always_comb begin
        resolve          = ex_valid & ex_is_branch;
        eq               = ex_rs_data == ex_rt_data;
        taken            = (br_sel_e'(ex_branch_ne) == BR_BNE) ? ~eq : eq;
        wrong            = taken != ex_prediction;
        stall            = resolve & full & ~train_ready;
        push             = resolve & ~stall;
        flush            = push & wrong;
        redirect_pc      = (flush & taken) ? ex_target : ex_save_pc;
        train_valid      = ~empty;
        pop              = train_valid & train_ready;
        wr_rec           = '{pc: BRU_PC_WIDTH'(ex_pc), taken: taken, mispredict: wrong};
        train_pc         = PC_WIDTH'(rd_rec.pc);
        train_taken      = rd_rec.taken;
        train_mispredict = rd_rec.mispredict;
    end

    bru_train_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .wr_rec (wr_rec),
        .rd_rec (rd_rec),
        .full   (full),
        .empty  (empty)
    );

`ifdef BRU_STATS_EN
    logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
    logic [CNT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;

    // Saturate at all-ones rather than wrap.
    always_comb begin
        branch_count_d     = (push && !(&branch_count_q)) ? branch_count_q + CNT_WIDTH'(1) : branch_count_q;
        mispredict_count_d = (flush && !(&mispredict_count_q)) ? mispredict_count_q + CNT_WIDTH'(1) : mispredict_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;
`else
    assign branch_count     = '0;
    assign mispredict_count = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed scenarios plus a queue scoreboard of training records.
module tb_branch_resolve_unit;
`ifdef BRU_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic        mis;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid, ex_is_branch, ex_branch_ne, ex_prediction, train_ready;
    logic [31:0] ex_rs_data, ex_rt_data, ex_pc, ex_target, ex_save_pc;
    logic        flush, stall, train_valid, train_taken, train_mispredict;
    logic [31:0] redirect_pc, train_pc, branch_count, mispredict_count;

    int   checks = 0;
    int   errors = 0;
    rec_t q[$];
    int   bc = 0;
    int   mc = 0;
    logic do_pop = 1'b0, do_push = 1'b0, m_flush = 1'b0;
    rec_t new_rec;

    branch_resolve_unit dut (
        .clk              (clk),
        .reset            (reset),
        .ex_valid         (ex_valid),
        .ex_is_branch     (ex_is_branch),
        .ex_branch_ne     (ex_branch_ne),
        .ex_rs_data       (ex_rs_data),
        .ex_rt_data       (ex_rt_data),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .ex_save_pc       (ex_save_pc),
        .ex_prediction    (ex_prediction),
        .flush            (flush),
        .redirect_pc      (redirect_pc),
        .stall            (stall),
        .train_valid      (train_valid),
        .train_ready      (train_ready),
        .train_pc         (train_pc),
        .train_taken      (train_taken),
        .train_mispredict (train_mispredict),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    // Reference model evaluated mid-cycle; committed on the following edge.
    always @(negedge clk) begin
        logic res, tk, st, ps;
        if (reset) begin
            do_pop  = 1'b0;
            do_push = 1'b0;
            m_flush = 1'b0;
        end else begin
            res = ex_valid & ex_is_branch;
            tk  = (ex_rs_data == ex_rt_data) ^ ex_branch_ne;
            st  = res && q.size() == 4 && !train_ready;
            ps  = res && !st;
            m_flush = ps && (tk != ex_prediction);
            checks++;
            if (train_valid !== (q.size() != 0)) begin
                errors++;
                $display("FAIL sb_valid got %0b want %0b", train_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                checks++;
                if ({train_pc, train_taken, train_mispredict} !== q[0]) begin
                    errors++;
                    $display("FAIL sb_record got %h/%0b/%0b want %h/%0b/%0b", train_pc, train_taken,
                             train_mispredict, q[0].pc, q[0].taken, q[0].mis);
                end
            end
            checks++;
            if (stall !== st || flush !== m_flush) begin
                errors++;
                $display("FAIL sb_ctrl stall/flush got %0b/%0b want %0b/%0b", stall, flush, st, m_flush);
            end
            if (m_flush) begin
                checks++;
                if (redirect_pc !== (tk ? ex_target : ex_save_pc)) begin
                    errors++;
                    $display("FAIL sb_redirect got %h want %h", redirect_pc, tk ? ex_target : ex_save_pc);
                end
            end
            checks++;
            if (branch_count !== (STATS ? bc : 0) || mispredict_count !== (STATS ? mc : 0)) begin
                errors++;
                $display("FAIL sb_counts got %0d/%0d want %0d/%0d", branch_count, mispredict_count,
                         STATS ? bc : 0, STATS ? mc : 0);
            end
            do_pop  = q.size() != 0 && train_ready;
            do_push = ps;
            new_rec = '{pc: ex_pc, taken: tk, mis: tk != ex_prediction};
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            bc = 0;
            mc = 0;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(new_rec);
                bc++;
                if (new_rec.mis) mc++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic ne, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] pc, input logic [31:0] tg, input logic [31:0] sv, input logic pr);
        ex_valid      = v;
        ex_is_branch  = v;
        ex_branch_ne  = ne;
        ex_rs_data    = rs;
        ex_rt_data    = rt;
        ex_pc         = pc;
        ex_target     = tg;
        ex_save_pc    = sv;
        ex_prediction = pr;
    endtask

    task automatic bubble();
        drv(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        train_ready = 1'b1;
        bubble();
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (train_valid !== 1'b0 || train_pc !== 32'h0 || train_taken !== 1'b0 || train_mispredict !== 1'b0) begin
            errors++;
            $display("FAIL reset_train got %0b/%h/%0b/%0b want 0/0/0/0", train_valid, train_pc, train_taken, train_mispredict);
        end
        checks++;
        if (branch_count !== 32'd0 || mispredict_count !== 32'd0 || flush !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %0d/%0d/%0b/%0b want 0/0/0/0", branch_count, mispredict_count, flush, stall);
        end
    endtask

    task automatic test_beq_correct();
        tick();
        drv(1'b1, 1'b0, 5, 5, 32'h100, 32'h200, 32'h104, 1'b1);
        #1;
        checks++;
        if (flush !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL beq_ok_flush got %0b/%0b want 0/0", flush, stall);
        end
        tick();
        bubble();
        #1;
        checks++;
        if ({train_valid, train_pc, train_taken, train_mispredict} !== {1'b1, 32'h100, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL beq_ok_rec got %0b/%h/%0b/%0b want 1/100/1/0", train_valid, train_pc, train_taken, train_mispredict);
        end
        checks++;
        if (branch_count !== (STATS ? 32'd1 : 32'd0)) begin
            errors++;
            $display("FAIL beq_ok_count got %0d want %0d", branch_count, STATS ? 1 : 0);
        end
    endtask

    task automatic test_bne_mispredict();
        tick();
        drv(1'b1, 1'b1, 7, 7, 32'h200, 32'h40, 32'h11, 1'b1);
        #1;
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h11) begin
            errors++;
            $display("FAIL bne_flush got %0b/%h want 1/11", flush, redirect_pc);
        end
        tick();
        bubble();
        #1;
        checks++;
        if ({train_valid, train_pc, train_taken, train_mispredict} !== {1'b1, 32'h200, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL bne_rec got %0b/%h/%0b/%0b want 1/200/0/1", train_valid, train_pc, train_taken, train_mispredict);
        end
        checks++;
        if (mispredict_count !== (STATS ? 32'd1 : 32'd0)) begin
            errors++;
            $display("FAIL bne_count got %0d want %0d", mispredict_count, STATS ? 1 : 0);
        end
    endtask

    task automatic test_beq_not_predicted();
        tick();
        drv(1'b1, 1'b0, 3, 3, 32'h300, 32'h80, 32'h304, 1'b0);
        #1;
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h80) begin
            errors++;
            $display("FAIL beq_nt_flush got %0b/%h want 1/80", flush, redirect_pc);
        end
        tick();
        bubble();
        #1;
        checks++;
        if (flush !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL beq_nt_bubble got %0b/%0b want 0/0", flush, stall);
        end
    endtask

    task automatic test_stall();
        tick();
        train_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            drv(1'b1, 1'b0, i, i, 32'h400 + 4 * i, 32'h500, 32'h404 + 4 * i, 1'b1);
        end
        tick();
        drv(1'b1, 1'b0, 1, 2, 32'h410, 32'h600, 32'h414, 1'b1);
        #1;
        checks++;
        if (stall !== 1'b1 || flush !== 1'b0) begin
            errors++;
            $display("FAIL stall_raise got %0b/%0b want 1/0", stall, flush);
        end
        tick();
        checks++;
        if (stall !== 1'b1 || branch_count !== (STATS ? 32'd7 : 32'd0)) begin
            errors++;
            $display("FAIL stall_hold got %0b/%0d want 1/%0d", stall, branch_count, STATS ? 7 : 0);
        end
        train_ready = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || flush !== 1'b1 || redirect_pc !== 32'h414) begin
            errors++;
            $display("FAIL stall_release got %0b/%0b/%h want 0/1/414", stall, flush, redirect_pc);
        end
        tick();
        bubble();
        train_ready = 1'b0;
        #1;
        checks++;
        if (branch_count !== (STATS ? 32'd8 : 32'd0) || mispredict_count !== (STATS ? 32'd3 : 32'd0)) begin
            errors++;
            $display("FAIL stall_counts got %0d/%0d want %0d/%0d", branch_count, mispredict_count, STATS ? 8 : 0, STATS ? 3 : 0);
        end
        drv(1'b1, 1'b0, 9, 9, 32'h420, 32'h700, 32'h424, 1'b1);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL stall_still_full got %0b want 1", stall);
        end
        bubble();
        train_ready = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_reset_mid();
        train_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            drv(1'b1, 1'b0, 1, 1, 32'h800 + 4 * i, 32'h900, 32'h804 + 4 * i, 1'b1);
        end
        tick();
        bubble();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (train_valid !== 1'b0 || branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid got %0b/%0d/%0d want 0/0/0", train_valid, branch_count, mispredict_count);
        end
        train_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic ne, eq, tk;
        for (int i = 0; i < 10; i++) begin
            ne = 1'(i % 2);
            eq = (i % 3) == 0;
            tk = eq ^ ne;
            tick();
            drv(1'b1, ne, i, eq ? i : i + 1, 32'hA00 + 4 * i, 32'h1000 + 16 * i, 32'h2000 + 16 * i, ~tk);
            #1;
            checks++;
            if (flush !== 1'b1 || redirect_pc !== (tk ? 32'h1000 + 16 * i : 32'h2000 + 16 * i)) begin
                errors++;
                $display("FAIL b2b_flush[%0d] got %0b/%h want 1/%h", i, flush, redirect_pc,
                         tk ? 32'h1000 + 16 * i : 32'h2000 + 16 * i);
            end
            tick();
            bubble();
        end
        for (int i = 0; i < 300; i++) begin
            tick();
            train_ready = 1'($urandom_range(0, 3) != 0);
            if (m_flush) bubble();
            else if (!stall)
                drv(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom, $urandom, $urandom, 1'($urandom));
        end
        bubble();
        train_ready = 1'b1;
        repeat (6) tick();
    endtask

    initial begin
        test_reset();
        test_beq_correct();
        test_bne_mispredict();
        test_beq_not_predicted();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
